// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: picks the oldest mispredicted branch for a held recovery request
// and queues conditional-branch outcomes for predictor training.
module branch_resolve_unit #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int PC_WIDTH     = 32,
  parameter int AL_PTR_WIDTH = 6,
  parameter int GHIST_WIDTH  = 10,
  parameter int UPD_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ISSUE_WIDTH-1:0]               br_valid,
  input  logic [ISSUE_WIDTH-1:0]               br_mispred,
  input  logic [ISSUE_WIDTH-1:0]               br_is_cond,
  input  logic [ISSUE_WIDTH-1:0]               br_is_ax,
  input  logic [ISSUE_WIDTH-1:0]               br_taken,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]      br_addr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]      br_next,
  input  logic [ISSUE_WIDTH*GHIST_WIDTH-1:0]   br_ghist,
  input  logic [ISSUE_WIDTH*2-1:0]             br_pht,
  input  logic [ISSUE_WIDTH*AL_PTR_WIDTH-1:0]  br_alptr,
  input  logic [AL_PTR_WIDTH-1:0]              al_head_ptr,
  output logic                                 rec_req,
  output logic [PC_WIDTH-1:0]                  rec_target,
  output logic [AL_PTR_WIDTH-1:0]              rec_alptr,
  input  logic                                 rec_ack,
  output logic                                 upd_valid,
  input  logic                                 upd_ready,
  output logic [PC_WIDTH-1:0]                  upd_addr,
  output logic                                 upd_taken,
  output logic [GHIST_WIDTH-1:0]               upd_ghist,
  output logic [1:0]                           upd_pht,
  output logic                                 upd_stall,
  output logic [7:0]                           upd_drop_cnt
);
  localparam int PW = $clog2(UPD_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = PC_WIDTH + GHIST_WIDTH + 3;
  typedef enum logic {IDLE, REQ} state_t;
  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     tgt_q, tgt_d;
  logic [AL_PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic                    cand_v;
  logic [PC_WIDTH-1:0]     cand_tgt;
  logic [AL_PTR_WIDTH-1:0] cand_ptr, cand_age;
  logic [EW-1:0]           mem_q [UPD_DEPTH];
  logic [EW-1:0]           mem_d [UPD_DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d, idx;
  logic [CW-1:0]           count_q, count_d, free, n_push;
  logic [7:0]              drop_q, drop_d, n_drop;
  logic [8:0]              drop_sum;
  logic                    pop;

  function automatic logic [AL_PTR_WIDTH-1:0] age(input logic [AL_PTR_WIDTH-1:0] p);
    return p - al_head_ptr;
  endfunction

  // strict less-than keeps the lower lane on equal age
  always_comb begin
    cand_v   = 1'b0;
    cand_tgt = '0;
    cand_ptr = '0;
    cand_age = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (br_valid[i] && br_mispred[i] &&
          (!cand_v || age(br_alptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH]) < cand_age)) begin
        cand_v   = 1'b1;
        cand_tgt = br_next[i*PC_WIDTH +: PC_WIDTH];
        cand_ptr = br_alptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
        cand_age = age(br_alptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH]);
      end
    end
  end

  // candidates arriving with the ack are younger or flushed, so they are dropped
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (cand_v) begin
        state_d = REQ;
        tgt_d   = cand_tgt;
        ptr_d   = cand_ptr;
      end
    end else if (rec_ack) begin
      state_d = IDLE;
    end else if (cand_v && cand_age < age(ptr_q)) begin
      tgt_d = cand_tgt;
      ptr_d = cand_ptr;
    end
  end

  assign rec_req    = state_q == REQ;
  assign rec_target = tgt_q;
  assign rec_alptr  = ptr_q;

  assign upd_valid = count_q != '0;
  assign pop       = upd_valid && upd_ready;
  assign free      = CW'(UPD_DEPTH) - count_q + CW'(pop);
  assign upd_stall = (CW'(UPD_DEPTH) - count_q) < CW'(ISSUE_WIDTH);
  assign upd_drop_cnt = drop_q;
  assign {upd_addr, upd_taken, upd_ghist, upd_pht} = upd_valid ? mem_q[rd_q] : '0;

  // lanes claim consecutive slots in order, so overflow always sheds the highest lanes
  always_comb begin
    mem_d  = mem_q;
    n_push = '0;
    n_drop = '0;
    idx    = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (br_valid[i] && br_is_cond[i] && !br_is_ax[i]) begin
        if (n_push < free) begin
          idx        = wr_q + n_push[PW-1:0];
          mem_d[idx] = {br_addr[i*PC_WIDTH +: PC_WIDTH], br_taken[i],
                        br_ghist[i*GHIST_WIDTH +: GHIST_WIDTH], br_pht[i*2 +: 2]};
          n_push     = n_push + 1'b1;
        end else begin
          n_drop = n_drop + 1'b1;
        end
      end
    end
    wr_d     = wr_q + n_push[PW-1:0];
    rd_d     = rd_q + PW'(pop);
    count_d  = count_q + n_push - CW'(pop);
    drop_sum = {1'b0, drop_q} + {1'b0, n_drop};
    drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      mem_q   <= mem_d;
    end
  end
endmodule
